// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC unit with stall, trap redirect and circular return-address stack
//
// Ports:
//   clk, reset                   clock and asynchronous active-high reset
//   stall                        hold pc and RAS this cycle
//   jump_sel                     00 seq/branch, 01 direct jump, 10 jump-register, 11 return
//   branch_taken, branch_target  conditional branch select and target
//   jump_target, jump_reg        direct-jump target; register target / empty-return fallback
//   ras_push                     link instruction: push pc_plus4
//   pc, pc_plus4, next_pc        registered pc, pc+4, selected target before the trap check
//   ras_top, ras_empty, ras_full return-address-stack status
//   misalign_err                 one-cycle pulse after a trap redirect
module pc_sequencer #(
    parameter int              WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] TRAP_PC   = WIDTH'(32'h80),
    parameter int              RAS_DEPTH  = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       jump_sel,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] jump_reg,
    input  logic             ras_push,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             misalign_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
    // Low-bit mask of the bits that must be zero; an all-zero mask disables trapping.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] ras_count;

    logic misaligned;
    logic do_pop;
    logic do_push;

    assign pc_plus4  = pc + WIDTH'(32'd4);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_MAX);
    assign ras_top   = ras_empty ? '0 : ras_mem[top_ptr];

    always_comb begin
        next_pc = pc_plus4;
        case (jump_sel)
            2'b00:   next_pc = branch_taken ? branch_target : pc_plus4;
            2'b01:   next_pc = jump_target;
            2'b10:   next_pc = jump_reg;
            default: next_pc = ras_empty ? jump_reg : ras_top;
        endcase
    end

    assign misaligned = |(next_pc & ALIGN_MASK);

    // A pop on an empty stack is a no-op; push+pop on an empty stack degrades to a push.
    assign do_pop  = (jump_sel == 2'b11) && !ras_empty;
    assign do_push = ras_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
            top_ptr      <= '0;
            ras_count    <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (stall) begin
            misalign_err <= 1'b0;
        end else if (misaligned) begin
            pc           <= TRAP_PC;
            misalign_err <= 1'b1;
        end else begin
            pc           <= next_pc;
            misalign_err <= 1'b0;
            if (do_push && do_pop) begin
                // Call-from-return: replace the entry being consumed.
                ras_mem[top_ptr] <= pc_plus4;
            end else if (do_push) begin
                // When full this lands on the oldest entry, giving circular overwrite.
                ras_mem[top_ptr + PTR_W'(1)] <= pc_plus4;
                top_ptr <= top_ptr + PTR_W'(1);
                if (!ras_full) begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (do_pop) begin
                top_ptr   <= top_ptr - PTR_W'(1);
                ras_count <= ras_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  jump_sel;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jump_reg;
    logic        ras_push;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        misalign_err;

    int total;
    int bad;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .jump_sel     (jump_sel),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .jump_reg     (jump_reg),
        .ras_push     (ras_push),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .ras_top      (ras_top),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        stall = 1'b0;
        jump_sel = 2'b00;
        branch_taken = 1'b0;
        branch_target = '0;
        jump_target = '0;
        jump_reg = '0;
        ras_push = 1'b0;
        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_empty", {31'd0, ras_empty}, 32'd1);
        check("rst_full", {31'd0, ras_full}, 32'd0);
        check("rst_top", ras_top, 32'h0);
        check("rst_mis", {31'd0, misalign_err}, 32'd0);
        check("rst_plus4", pc_plus4, 32'h4);
        reset = 1'b0;

        step(); check("seq1", pc, 32'h4);
        step(); check("seq2", pc, 32'h8);
        step(); check("seq3", pc, 32'hC);
        reset = 1'b1;
        settle(); check("async_rst", pc, 32'h0);
        reset = 1'b0;
        step(); check("seq_a", pc, 32'h4);
        step(); check("seq_b", pc, 32'h8);

        branch_taken = 1'b1; branch_target = 32'h40;
        settle(); check("br_next", next_pc, 32'h40);
        step(); check("br_pc", pc, 32'h40);
        branch_taken = 1'b0;
        jump_sel = 2'b01; jump_target = 32'h100;
        step(); check("jmp_pc", pc, 32'h100);
        jump_sel = 2'b10; jump_reg = 32'h200;
        step(); check("jr_pc", pc, 32'h200);
        stall = 1'b1; jump_sel = 2'b01;
        step(); check("stall_pc", pc, 32'h200);
        stall = 1'b0;

        jump_target = 32'h10;
        step(); check("to_10", pc, 32'h10);
        jump_target = 32'h100; ras_push = 1'b1;
        step(); check("call_pc", pc, 32'h100);
        check("call_top", ras_top, 32'h14);
        check("call_nempty", {31'd0, ras_empty}, 32'd0);
        ras_push = 1'b0; jump_sel = 2'b11;
        settle(); check("ret_next", next_pc, 32'h14);
        step(); check("ret_pc", pc, 32'h14);
        check("ret_empty", {31'd0, ras_empty}, 32'd1);
        jump_reg = 32'h300;
        settle(); check("epop_next", next_pc, 32'h300);
        step(); check("epop_pc", pc, 32'h300);
        check("epop_empty", {31'd0, ras_empty}, 32'd1);
        check("epop_top", ras_top, 32'h0);

        jump_sel = 2'b01; jump_target = 32'h0;
        step(); check("to_0", pc, 32'h0);
        jump_sel = 2'b00; ras_push = 1'b1;
        step(); step(); step(); step();
        check("push4_full", {31'd0, ras_full}, 32'd1);
        check("push4_top", ras_top, 32'h10);
        step();
        check("push5_full", {31'd0, ras_full}, 32'd1);
        check("push5_top", ras_top, 32'h14);
        check("push5_pc", pc, 32'h14);
        ras_push = 1'b0; jump_sel = 2'b11; jump_reg = 32'h300;
        step(); check("pop1", pc, 32'h14);
        step(); check("pop2", pc, 32'h10);
        step(); check("pop3", pc, 32'hC);
        step(); check("pop4", pc, 32'h8);
        check("pop_empty", {31'd0, ras_empty}, 32'd1);
        settle(); check("pop_fallback", next_pc, 32'h300);

        jump_sel = 2'b00; ras_push = 1'b1;
        step(); check("pre_mis_top", ras_top, 32'hC);
        jump_sel = 2'b10; jump_reg = 32'h202;
        settle(); check("mis_next", next_pc, 32'h202);
        step(); check("mis_pc", pc, 32'h80);
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_nopush", ras_top, 32'hC);
        ras_push = 1'b0; jump_sel = 2'b00;
        step(); check("mis_pulse", {31'd0, misalign_err}, 32'd0);
        check("after_trap", pc, 32'h84);

        jump_sel = 2'b01; jump_target = 32'h10;
        step(); check("to_10b", pc, 32'h10);
        jump_target = 32'h50; ras_push = 1'b1;
        step(); check("to_50", pc, 32'h50);
        check("top_14", ras_top, 32'h14);
        jump_sel = 2'b11;
        settle(); check("pp_next", next_pc, 32'h14);
        step(); check("pp_pc", pc, 32'h14);
        check("pp_top", ras_top, 32'h54);
        ras_push = 1'b0;
        step(); check("pp_pop_pc", pc, 32'h54);
        check("pp_below", ras_top, 32'hC);
        step(); check("pp_pop2_pc", pc, 32'hC);
        check("pp_empty", {31'd0, ras_empty}, 32'd1);

        jump_sel = 2'b01; jump_target = 32'hFFFF_FFFC;
        step(); check("wrap_pc", pc, 32'hFFFF_FFFC);
        jump_sel = 2'b00;
        settle(); check("wrap_plus4", pc_plus4, 32'h0);
        check("wrap_next", next_pc, 32'h0);
        step(); check("wrap_step", pc, 32'h0);

        stall = 1'b1; reset = 1'b1;
        step(); check("stall_rst_pc", pc, 32'h0);
        reset = 1'b0;
        step(); check("stall_rst_hold", pc, 32'h0);
        stall = 1'b0;
        step(); check("post_stall", pc, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
